// File: rtl/data_array_arbiter.sv
// data_array_arbiter
//   Shares the single RW port of the 512x128 L1 data array between three
//   requesters: line refill (write-only bursts), core load/store and
//   probe/eviction. At most one array access is issued per cycle. Read data
//   comes back one cycle later, tagged with its source.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | refill has priority, then the round-robin core/probe winner
//   BURST | refill burst open; only refill is granted, except for the
//         | forced core/probe slot at the starvation limit
//
// Ports
//   clock, reset_n           : clock, synchronous active-low reset
//   refill_*                 : refill write beats (valid/ready, last)
//   core_*, probe_*          : read/write requests (valid/ready, write)
//   sram_*                   : direct drive of the array wrapper pins
//   resp_valid/src/data      : read response (src 0 = core, 1 = probe)
module data_array_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 128,
  parameter int LANES        = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              refill_valid,
  output logic              refill_ready,
  input  logic [ADDR_W-1:0] refill_addr,
  input  logic [DATA_W-1:0] refill_wdata,
  input  logic [LANES-1:0]  refill_wmask,
  input  logic              refill_last,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic              core_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [LANES-1:0]  core_wmask,
  input  logic              probe_valid,
  output logic              probe_ready,
  input  logic              probe_write,
  input  logic [ADDR_W-1:0] probe_addr,
  input  logic [DATA_W-1:0] probe_wdata,
  input  logic [LANES-1:0]  probe_wmask,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic [LANES-1:0]  sram_wmask,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              resp_valid,
  output logic              resp_src,
  output logic [DATA_W-1:0] resp_data
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic       rr, rr_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       resp_valid_q, resp_src_q;

  logic cp_any, forced, pick_probe;
  logic grant_refill, grant_cp, grant_core, grant_probe;

  // Grant decision
  always_comb begin
    cp_any       = core_valid | probe_valid;
    forced       = (starve_cnt == LIMIT);
    grant_refill = 1'b0;
    grant_cp     = 1'b0;
    if (core_valid && probe_valid) pick_probe = rr;
    else                           pick_probe = probe_valid;
    if (reset_n) begin
      if (forced && cp_any)            grant_cp     = 1'b1;
      else if (refill_valid)           grant_refill = 1'b1;
      // In BURST a gap in refill beats is an idle cycle, not a core/probe slot.
      else if (state == IDLE && cp_any) grant_cp    = 1'b1;
    end
    grant_core  = grant_cp & ~pick_probe;
    grant_probe = grant_cp &  pick_probe;
  end

  assign refill_ready = grant_refill;
  assign core_ready   = grant_core;
  assign probe_ready  = grant_probe;

  // Array pin drive for the granted requester
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (grant_refill) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = refill_addr;
      sram_wdata = refill_wdata;
      sram_wmask = refill_wmask;
    end else if (grant_core) begin
      sram_en    = 1'b1;
      sram_wmode = core_write;
      sram_addr  = core_addr;
      sram_wdata = core_wdata;
      sram_wmask = core_write ? core_wmask : '0;
    end else if (grant_probe) begin
      sram_en    = 1'b1;
      sram_wmode = probe_write;
      sram_addr  = probe_addr;
      sram_wdata = probe_wdata;
      sram_wmask = probe_write ? probe_wmask : '0;
    end
  end

  // Next state, round-robin pointer and starvation counter
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr;
    starve_nxt = starve_cnt;
    if (grant_refill) state_nxt = refill_last ? IDLE : BURST;
    if (grant_cp)     rr_nxt    = ~pick_probe;
    if (grant_cp || !cp_any)    starve_nxt = 4'd0;
    else if (starve_cnt != LIMIT) starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr           <= 1'b0;
      starve_cnt   <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_src_q   <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr           <= rr_nxt;
      starve_cnt   <= starve_nxt;
      resp_valid_q <= (grant_core & ~core_write) | (grant_probe & ~probe_write);
      if (grant_cp) resp_src_q <= grant_probe;
    end
  end

  // A response registered just before reset is dropped while reset is low.
  assign resp_valid = resp_valid_q & reset_n;
  assign resp_src   = resp_src_q;
  assign resp_data  = sram_rdata;

endmodule

// File: tb/tb_data_array_arbiter.sv
module tb_data_array_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 128;
  localparam int LANES  = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              refill_valid, refill_ready, refill_last;
  logic [ADDR_W-1:0] refill_addr;
  logic [DATA_W-1:0] refill_wdata;
  logic [LANES-1:0]  refill_wmask;
  logic              core_valid, core_ready, core_write;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [LANES-1:0]  core_wmask;
  logic              probe_valid, probe_ready, probe_write;
  logic [ADDR_W-1:0] probe_addr;
  logic [DATA_W-1:0] probe_wdata;
  logic [LANES-1:0]  probe_wmask;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [LANES-1:0]  sram_wmask;
  logic [DATA_W-1:0] sram_rdata;
  logic              resp_valid, resp_src;
  logic [DATA_W-1:0] resp_data;

  data_array_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_addr(refill_addr),
    .refill_wdata(refill_wdata), .refill_wmask(refill_wmask), .refill_last(refill_last),
    .core_valid(core_valid), .core_ready(core_ready), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_wmask(core_wmask),
    .probe_valid(probe_valid), .probe_ready(probe_ready), .probe_write(probe_write),
    .probe_addr(probe_addr), .probe_wdata(probe_wdata), .probe_wmask(probe_wmask),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata),
    .resp_valid(resp_valid), .resp_src(resp_src), .resp_data(resp_data)
  );

  always #5 clock = ~clock;

  // Behavioural single-port array
  logic [DATA_W-1:0] mem [0:511];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] nw,
                                              input logic [LANES-1:0] m);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < LANES; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wmask);
      else            sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct packed {
    logic              src;
    logic [DATA_W-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_grant(input string name, input logic er, input logic ec, input logic ep);
    chk({name, "_refill_ready"}, refill_ready, er);
    chk({name, "_core_ready"},   core_ready,   ec);
    chk({name, "_probe_ready"},  probe_ready,  ep);
    chk({name, "_sram_en"},      sram_en,      er | ec | ep);
  endtask

  // Response monitor
  always @(negedge clock) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual src=%0d data=%h required none", resp_src, resp_data);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_src",  resp_src,  e.src);
        chk("resp_data", resp_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    refill_valid = 1'b0; refill_last = 1'b0;
    core_valid   = 1'b0; core_write  = 1'b0;
    probe_valid  = 1'b0; probe_write = 1'b0;
  endtask

  task automatic set_core(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [LANES-1:0] m);
    core_valid = v; core_write = w; core_addr = a; core_wdata = d; core_wmask = m;
  endtask

  task automatic set_probe(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [LANES-1:0] m);
    probe_valid = v; probe_write = w; probe_addr = a; probe_wdata = d; probe_wmask = m;
  endtask

  task automatic set_refill(input logic v, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic last);
    refill_valid = v; refill_addr = a; refill_wdata = d; refill_wmask = '1; refill_last = last;
  endtask

  task automatic reset_pulse();
    idle_in();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  localparam logic [DATA_W-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] PAT_FF = {16{8'hFF}};
  localparam logic [DATA_W-1:0] PAT_13 = {16{8'h13}};

  initial begin
    int beat;
    logic exp_core;
    logic [7:0] bv;

    idle_in();
    reset_n = 1'b0;
    refill_addr = '0; refill_wdata = '0; refill_wmask = '0;
    core_addr = '0; core_wdata = '0; core_wmask = '0;
    probe_addr = '0; probe_wdata = '0; probe_wmask = '0;

    // Reset: valids held high, nothing may be granted
    core_valid = 1'b1; probe_valid = 1'b1; refill_valid = 1'b1;
    tick(); tick();
    chk_grant("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_resp_src",   resp_src,   1'b0);
    idle_in();
    reset_n = 1'b1;
    tick();

    // Core write 0xA5 to 0x1A5, then read it back
    set_core(1'b1, 1'b1, 9'h1A5, PAT_A5, 16'hFFFF); #1;
    chk_grant("cwr", 1'b0, 1'b1, 1'b0);
    chk("cwr_wmode", sram_wmode, 1'b1);
    chk("cwr_wmask", sram_wmask, 16'hFFFF);
    chk("cwr_addr",  sram_addr,  9'h1A5);
    tick();
    set_core(1'b1, 1'b0, 9'h1A5, '0, 16'hFFFF); #1;
    chk_grant("crd", 1'b0, 1'b1, 1'b0);
    chk("crd_wmode", sram_wmode, 1'b0);
    chk("crd_wmask", sram_wmask, 16'h0000);
    exp_q.push_back('{src: 1'b0, data: PAT_A5});
    tick();

    // Byte-lane masked write over a zeroed row
    set_core(1'b1, 1'b1, 9'h010, '0, 16'hFFFF); #1;
    chk_grant("zero", 1'b0, 1'b1, 1'b0);
    tick();
    set_core(1'b1, 1'b1, 9'h010, PAT_FF, 16'h0001); #1;
    chk("mask_wmask", sram_wmask, 16'h0001);
    tick();
    set_core(1'b1, 1'b0, 9'h010, '0, 16'h0000); #1;
    chk_grant("mask_rd", 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{src: 1'b0, data: 128'hFF});
    tick();
    idle_in(); tick();

    // Core and probe contending after reset: strict alternation
    reset_pulse();
    set_core(1'b1, 1'b0, 9'h1A5, '0, '0);
    set_probe(1'b1, 1'b0, 9'h010, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_grant("rr", 1'b0, (i % 2) == 0, (i % 2) == 1);
      if ((i % 2) == 0) exp_q.push_back('{src: 1'b0, data: PAT_A5});
      else              exp_q.push_back('{src: 1'b1, data: 128'hFF});
      tick();
    end
    idle_in(); tick();

    // 8-beat refill with core waiting: forced slot after 4 refill beats,
    // and again right after the last beat
    beat = 0;
    for (int c = 0; c < 10; c++) begin
      bv = 8'(8'h10 + beat);
      set_refill(beat < 8, 9'(9'h100 + beat), {16{bv}}, beat == 7);
      set_core(1'b1, 1'b0, 9'h1A5, '0, '0);
      #1;
      exp_core = (c == 4) || (c == 9);
      chk_grant("burst", !exp_core && (beat < 8), exp_core, 1'b0);
      if (exp_core) exp_q.push_back('{src: 1'b0, data: PAT_A5});
      if (refill_ready) beat++;
      tick();
    end
    chk("burst_beats", 32'(beat), 32'd8);
    idle_in(); tick();
    set_core(1'b1, 1'b0, 9'h103, '0, '0); #1;
    chk_grant("refill_rd", 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{src: 1'b0, data: PAT_13});
    tick();
    idle_in(); tick();

    // Refill gap inside a burst while probe waits
    set_refill(1'b1, 9'h120, '0, 1'b0);
    set_probe(1'b1, 1'b0, 9'h010, '0, '0); #1;
    chk_grant("gap0", 1'b1, 1'b0, 1'b0);
    tick();
    refill_valid = 1'b0; #1;
    chk_grant("gap1", 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    chk_grant("gap2", 1'b0, 1'b0, 1'b0);
    tick();
    set_refill(1'b1, 9'h121, '0, 1'b1); #1;
    chk_grant("gap_last", 1'b1, 1'b0, 1'b0);
    tick();
    refill_valid = 1'b0; #1;
    chk_grant("gap_forced", 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{src: 1'b1, data: 128'hFF});
    tick();
    idle_in(); tick();

    // Reset mid-burst with a read granted the cycle before
    for (int c = 0; c < 5; c++) begin
      set_refill(1'b1, 9'(9'h130 + c), '0, 1'b0);
      set_core(1'b1, 1'b0, 9'h1A5, '0, '0);
      #1;
      chk_grant("rst_burst", c < 4, c == 4, 1'b0);
      tick();
    end
    reset_n = 1'b0;
    core_valid = 1'b0; #1;
    chk_grant("rst_low", 1'b0, 1'b0, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    tick();
    reset_n = 1'b1;
    refill_valid = 1'b0;
    set_core(1'b1, 1'b0, 9'h103, '0, '0); #1;
    chk("post_rst_resp_valid", resp_valid, 1'b0);
    chk_grant("post_rst", 1'b0, 1'b1, 1'b0);
    exp_q.push_back('{src: 1'b0, data: PAT_13});
    tick();
    idle_in(); tick(); tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_array_arbiter.md
# data_array_arbiter

Sequencing and arbitration controller for the single-port 512x128 L1 data array macro with its 16 byte-lane write mask. It shares the array's one RW port between three requesters: line refill (write-only, bursts), core load/store, and probe/eviction read/write. Per cycle it issues at most one SRAM access and returns read data one cycle later, tagged with the source. It sits between the cache pipeline and the data-array wrapper, and drives the wrapper's addr/en/wmode/wdata/wmask pins directly.

## Interface
Parameters:
- ADDR_W, 9, array index width (512 rows)
- DATA_W, 128, row width in bits
- LANES, 16, byte lanes in the write mask (DATA_W/8)
- STARVE_LIMIT, 4, consecutive denied cycles before core/probe is forced a slot (range 1..15)

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- refill_valid / refill_ready  in/out  1  refill write request handshake
- refill_addr, refill_wdata, refill_wmask  in  ADDR_W, DATA_W, LANES  refill row, data, lane mask
- refill_last  in  1  final beat of the refill burst
- core_valid / core_ready  in/out  1  core request handshake
- core_write, core_addr, core_wdata, core_wmask  in  1, ADDR_W, DATA_W, LANES  core op: 1 = write, 0 = read
- probe_valid / probe_ready, probe_write, probe_addr, probe_wdata, probe_wmask  same as core, for probe
- sram_en, sram_wmode  out  1  array enable and write mode
- sram_addr, sram_wdata, sram_wmask  out  ADDR_W, DATA_W, LANES  array address, data, mask
- sram_rdata  in  DATA_W  array read data, valid the cycle after a read enable
- resp_valid  out  1  read data valid
- resp_src  out  1  0 = core, 1 = probe
- resp_data  out  DATA_W  read data (sram_rdata passed through)

## Operation
- A grant is a same-cycle handshake: X_ready is a combinational function of the valids and registered state. A transfer happens when X_valid and X_ready are both high. At most one ready is high per cycle, and only when its valid is high.
- SRAM drive for the granted requester: sram_en=1, sram_addr=addr, sram_wmode=write (always 1 for refill), sram_wdata=wdata, sram_wmask=write ? wmask : 0. With no grant: sram_en=0, wmode=0, wmask=0, addr/wdata don't-care.
- State machine:
  - IDLE: the default state.
  - BURST: entered when a refill beat with refill_last=0 transfers in IDLE. Left for IDLE when a beat with refill_last=1 transfers.
- IDLE priority:
  - If starve_cnt == STARVE_LIMIT, grant the round-robin winner of core/probe.
  - Otherwise grant refill, then the round-robin winner of core/probe.
- BURST priority:
  - Only refill may be granted. The exception is the forced slot at starve_cnt == STARVE_LIMIT: one core/probe grant, during which refill_ready=0.
  - A cycle with refill_valid=0 in BURST is an idle cycle. Core/probe are not granted except by the forced slot.
- Round-robin:
  - A 1-bit pointer rr selects the preferred requester (0 = core).
  - When both core and probe are valid, the one selected by rr wins.
  - After any core or probe grant, rr points to the other requester.
- Starvation counter starve_cnt (4 bits, saturating at STARVE_LIMIT):
  - Increments in any cycle where (core_valid|probe_valid) is high and neither is granted.
  - Clears on any core/probe grant, and in any cycle with both core_valid and probe_valid low.
- Read response: on a core/probe read grant in cycle N, resp_valid=1 in N+1, with resp_src registered from N and resp_data=sram_rdata. There is no response backpressure. Writes produce no response.

## Timing
- Reset values: state=IDLE, rr=0, starve_cnt=0, resp_valid=0, resp_src=0. While reset_n=0, all readies and sram_en are 0.
- Reset asserted mid-burst or with a read in flight: the burst is abandoned (IDLE next), and any pending resp_valid is suppressed.
- Read latency: 1 cycle from handshake to resp_valid. A read can be granted every cycle, giving back-to-back responses.
- Write latency: the array is written at the edge that ends the handshake cycle. A read of the same row in the next cycle returns the new data.
- Simultaneous events:
  - refill_last transferring in the same cycle as starve_cnt reaching STARVE_LIMIT: the forced slot happens in the following IDLE cycle.
  - A forced slot with both core and probe valid follows rr.

## Test plan
- Single core read, addr 0x1A5, after a core write of 0xA5 in all lanes to 0x1A5 -> sram_en=1 and wmode=0 at N, resp_valid=1 at N+1, resp_src=0, resp_data all 0xA5.
- Core write with wmask=0x0001, data 0xFF.., over a row of 0x00 -> read back: only byte 0 is 0xFF, bytes 1-15 unchanged.
- Core and probe both valid continuously with reads, refill idle, after reset -> grants alternate core, probe, core, probe. resp_src is 0,1,0,1 one cycle later.
- 8-beat refill burst with core_valid held high, STARVE_LIMIT=4 -> refill granted for 4 cycles, then one core grant with refill_ready=0, then refill resumes. The burst ends on the beat with refill_last=1 and the state returns to IDLE.
- refill_valid drops for 2 cycles mid-burst while probe is valid -> no probe grant in those cycles (sram_en=0) unless starve_cnt hits the limit.
- reset_n pulsed low for 1 cycle mid-burst, with a read issued the cycle before -> resp_valid=0 after reset, state IDLE, and the next core request is granted immediately.
